encrypt_stream_core: RTL

Parametrised, flow-controlled successor of the fixed byte encrypt unit. It encrypts or decrypts one DW-bit word per cycle. Each word is bit-rotated and XORed with one of NKEYS runtime-loadable key words, and the active key advances every rot_freq accepted beats. The block sits between an upstream valid/ready source and a downstream valid/ready sink. It replaces the hard-wired key, permutation and HP_MODE variants.

---
 rtl/encrypt_stream_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/encrypt_stream_core.sv
// -----------------------------------------------------------------------------
// encrypt_stream_core
//
// Streaming word cipher with valid/ready flow control on both sides. Each
// accepted word is rotated and XORed with one of NKEYS runtime-loadable key
// registers. The active key advances every rot_freq accepted beats.
//
//   encrypt (mode=0): out = rotl(d, sh) ^ k
//   decrypt (mode=1): out = rotr(d ^ k, sh)
//
// Two-stage pipeline: S1 snapshots the word, key, mode and shift at
// acceptance; S2 (the output register) holds the processed result.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   mode       0 = encrypt, 1 = decrypt (sampled at acceptance)
//   shift_amt  rotate amount (sampled at acceptance)
//   rot_freq   accepted beats per key step, 0 freezes the key pointer
//   key_wr     key register write strobe
//   key_idx    key register index, out-of-range indices are ignored
//   key_wdata  key value to write
//   clr        synchronous flush of the pipeline and the key sequencing
//   in_valid / in_data / in_ready     upstream handshake
//   out_valid / out_data / out_ready  downstream handshake
//   key_ptr    index of the key the next accepted beat uses
//   beat_cnt   accepted beats since reset/clr, saturating
// -----------------------------------------------------------------------------
module encrypt_stream_core #(
    parameter int DW    = 8,
    parameter int NKEYS = 3,
    parameter int RFW   = 3,
    parameter int CW    = 16,
    localparam int SW   = $clog2(DW),
    localparam int KW   = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  shift_amt,
    input  logic [RFW-1:0] rot_freq,
    input  logic           key_wr,
    input  logic [KW-1:0]  key_idx,
    input  logic [DW-1:0]  key_wdata,
    input  logic           clr,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    input  logic           out_ready,
    output logic [KW-1:0]  key_ptr,
    output logic [CW-1:0]  beat_cnt
);

    // Rotations via a doubled word: the bits shifted out of one copy are
    // refilled from the other, so a shift of 0 is a plain pass-through.
    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d, input logic [SW-1:0] sh);
        logic [2*DW-1:0] t;
        t = {d, d} << sh;
        return t[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] d, input logic [SW-1:0] sh);
        logic [2*DW-1:0] t;
        t = {d, d} >> sh;
        return t[DW-1:0];
    endfunction

    logic [DW-1:0]  keys [NKEYS];
    logic [RFW-1:0] rot_cnt;

    logic           s1_v;
    logic [DW-1:0]  s1_data;
    logic [DW-1:0]  s1_key;
    logic           s1_mode;
    logic [SW-1:0]  s1_sh;

    logic           s2_adv;
    logic           s1_adv;
    logic           accept;
    logic [DW-1:0]  s1_result;
    logic [RFW:0]   rot_cnt_inc;
    logic           key_step;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    // The rst term keeps in_ready low while the block is held in reset.
    assign in_ready = rst && s1_adv && !clr;
    assign accept   = in_valid && in_ready;

    assign s1_result = s1_mode ? rotr(s1_data ^ s1_key, s1_sh)
                               : (rotl(s1_data, s1_sh) ^ s1_key);

    // Using >= rather than == means a rot_freq lowered below the current
    // count steps the key on the very next accepted beat.
    assign rot_cnt_inc = {1'b0, rot_cnt} + 1'b1;
    assign key_step    = (rot_freq != '0) && (rot_cnt_inc >= {1'b0, rot_freq});

    // Key register file; clr leaves the keys untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NKEYS; i++) begin
                keys[i] <= '0;
            end
        end else if (key_wr && (int'(key_idx) < NKEYS)) begin
            keys[key_idx] <= key_wdata;
        end
    end

    // Pipeline stages, key sequencing and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v      <= 1'b0;
            s1_data   <= '0;
            s1_key    <= '0;
            s1_mode   <= 1'b0;
            s1_sh     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            key_ptr   <= '0;
            rot_cnt   <= '0;
            beat_cnt  <= '0;
        end else if (clr) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
            key_ptr   <= '0;
            rot_cnt   <= '0;
            beat_cnt  <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_data <= s1_result;
                end
            end

            if (s1_adv) begin
                s1_v <= accept;
            end

            if (accept) begin
                // The key snapshot is read before any same-cycle key write lands.
                s1_data <= in_data;
                s1_key  <= keys[key_ptr];
                s1_mode <= mode;
                s1_sh   <= shift_amt;

                if (rot_freq != '0) begin
                    if (key_step) begin
                        rot_cnt <= '0;
                        key_ptr <= (key_ptr == KW'(NKEYS - 1)) ? '0 : key_ptr + 1'b1;
                    end else begin
                        rot_cnt <= rot_cnt + 1'b1;
                    end
                end

                if (beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule
